// File: rtl/or_circuit_pkg.sv
// Shared types and constants for the orCircuit exhaustive stimulus sequencer.
package or_circuit_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCapture,
      StDone
   } state_e;

   localparam int unsigned MISR_W    = 16;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam int unsigned CNT_W     = 14;

   // Bit positions of the observed outputs within obs = {t,n,r,k,m}
   localparam int unsigned OBS_M = 0;
   localparam int unsigned OBS_K = 1;
   localparam int unsigned OBS_R = 2;
   localparam int unsigned OBS_N = 3;
   localparam int unsigned OBS_T = 4;

endpackage

// File: rtl/or_circuit_misr.sv
// 16-bit multiple-input signature register; clear has priority over enable.
module or_circuit_misr
   import or_circuit_pkg::*;
#(
   parameter int unsigned IN_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [IN_W-1:0]   din,
   output logic [MISR_W-1:0] signature
);

   logic [MISR_W-1:0] sig_d;

   always_comb begin
      sig_d = {signature[MISR_W-2:0], 1'b0}
              ^ (signature[MISR_W-1] ? MISR_POLY : '0)
              ^ MISR_W'(din);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         signature <= '0;
      end else if (clr) begin
         signature <= '0;
      end else if (en) begin
         signature <= sig_d;
      end
   end

endmodule

// File: rtl/or_circuit_sequencer.sv
// Self-running exhaustive sweep of the orCircuit inputs with settle, capture,
// valid/ready result streaming, MISR compaction and per-output ones counting.
module or_circuit_sequencer
   import or_circuit_pkg::*;
#(
   parameter int unsigned DATA_W        = 9,
   parameter int unsigned CTRL_W        = 4,
   parameter int unsigned OBS_W         = 5,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned SWEEP_CTRL    = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic [CTRL_W-1:0]               ctrl_cfg,
   output logic [DATA_W-1:0]               data_out,
   output logic [CTRL_W-1:0]               ctrl_out,
   input  logic [OBS_W-1:0]                obs,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [CTRL_W+DATA_W+OBS_W-1:0]  res_data,
   output logic                            busy,
   output logic                            done,
   output logic [MISR_W-1:0]               signature,
   output logic [OBS_W*CNT_W-1:0]          ones_cnt
);

   localparam int unsigned IDX_W   = DATA_W + CTRL_W;
   localparam int unsigned NV_BITS = DATA_W + ((SWEEP_CTRL != 0) ? CTRL_W : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((64'd1 << NV_BITS) - 64'd1);
   localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

   state_e            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [SET_W-1:0]  set_cnt_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [OBS_W-1:0]  cap_q;

   logic start_run;
   logic accept;

   assign start_run = (state_q == StIdle) && start && !abort;
   // abort wins over the handshake, so a record is never half-accepted
   assign accept    = (state_q == StCapture) && res_ready && !abort;

   assign data_out = idx_q[DATA_W-1:0];
   assign ctrl_out = (SWEEP_CTRL != 0) ? idx_q[DATA_W +: CTRL_W] : ctrl_q;
   assign res_data = {ctrl_out, data_out, cap_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         set_cnt_q <= '0;
         ctrl_q    <= '0;
         cap_q     <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ones_cnt  <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_run) begin
                  idx_q     <= '0;
                  set_cnt_q <= SET_LOAD;
                  ctrl_q    <= ctrl_cfg;
                  busy      <= 1'b1;
                  ones_cnt  <= '0;
                  state_q   <= StSettle;
               end
            end
            StSettle, StCapture: begin
               if (abort) begin
                  idx_q     <= '0;
                  ctrl_q    <= '0;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_q   <= StIdle;
               end else if (state_q == StSettle) begin
                  if (set_cnt_q == '0) begin
                     cap_q     <= obs;
                     res_valid <= 1'b1;
                     state_q   <= StCapture;
                  end else begin
                     set_cnt_q <= set_cnt_q - 1'b1;
                  end
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  for (int j = 0; j < OBS_W; j++) begin
                     ones_cnt[j*CNT_W +: CNT_W] <= ones_cnt[j*CNT_W +: CNT_W] + CNT_W'(cap_q[j]);
                  end
                  if (idx_q == IDX_LAST) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     idx_q     <= idx_q + 1'b1;
                     set_cnt_q <= SET_LOAD;
                     state_q   <= StSettle;
                  end
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   or_circuit_misr #(
      .IN_W (OBS_W)
   ) u_misr (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_run),
      .en        (accept),
      .din       (cap_q),
      .signature (signature)
   );

endmodule
